// File: rtl/float_pkg.sv
// float_pkg: shared widths, field helpers and rounding-mode constants
// for the small-format floating-point blocks.
package float_pkg;
    localparam int DEF_EXP_W = 5;
    localparam int DEF_MAN_W = 6;
    localparam logic RND_TRUNC = 1'b0;
    localparam logic RND_RNE = 1'b1;
    function automatic int word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction
    function automatic int prod_w(input int man_w);
        return 2 * man_w + 2;
    endfunction
    // Fields are extracted from a zero-extended 64-bit word so one helper serves every format.
    function automatic logic sign_of(input logic [63:0] d, input int exp_w, input int man_w);
        logic [63:0] t;
        t = d >> (exp_w + man_w);
        return t[0];
    endfunction
    function automatic logic [63:0] exp_of(input logic [63:0] d, input int exp_w, input int man_w);
        return (d >> man_w) & ((64'd1 << exp_w) - 64'd1);
    endfunction
    function automatic logic [63:0] man_of(input logic [63:0] d, input int man_w);
        return d & ((64'd1 << man_w) - 64'd1);
    endfunction
endpackage

// File: rtl/float_mant_mul.sv
// float_mant_mul: registered unsigned mantissa multiplier with clock enable;
// plain RTL so a vendor multiplier core can replace it.
module float_mant_mul #(
    parameter int N = 7
) (
    input  logic           clk,
    input  logic           en,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    always_ff @(posedge clk)
        if (en) p <= (2*N)'(a) * (2*N)'(b);
endmodule

// File: rtl/float_mult_pipe.sv
// float_mult_pipe: 3-stage floating-point multiplier with valid/ready flow control,
// truncate or round-to-nearest-even, and overflow/underflow flags.
module float_mult_pipe import float_pkg::*; #(
    parameter  int EXP_W = DEF_EXP_W,
    parameter  int MAN_W = DEF_MAN_W,
    parameter  int BIAS  = 2 ** (EXP_W - 1) - 1,
    localparam int W     = word_w(EXP_W, MAN_W)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_1_i,
    input  logic [W-1:0] data_2_i,
    input  logic         round_mode_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_mult_o,
    output logic         overflow_o,
    output logic         underflow_o
);
    localparam int PW = prod_w(MAN_W);
    localparam int XW = EXP_W + 3;
    logic en;
    logic a_s, b_s;
    logic [EXP_W-1:0] a_e, b_e;
    logic [MAN_W-1:0] a_m, b_m;
    logic v1, s1_sign, s1_zero, s1_rne;
    logic [EXP_W:0] s1_es;
    logic [MAN_W:0] s1_ma, s1_mb;
    logic v2, s2_sign, s2_zero, s2_rne;
    logic [EXP_W:0] s2_es;
    logic [PW-1:0] s2_p;
    logic n, guard, sticky, inc, c, of, uf;
    logic [MAN_W-1:0] m_raw, m_rnd;
    logic [XW-1:0] e_pre, e_out;
    logic [W-1:0] res;
    // One enable for the whole pipe: it only freezes when the output is stuck.
    assign en = ~valid_o | ready_i;
    assign ready_o = en;
    assign a_s = sign_of(64'(data_1_i), EXP_W, MAN_W);
    assign b_s = sign_of(64'(data_2_i), EXP_W, MAN_W);
    assign a_e = EXP_W'(exp_of(64'(data_1_i), EXP_W, MAN_W));
    assign b_e = EXP_W'(exp_of(64'(data_2_i), EXP_W, MAN_W));
    assign a_m = MAN_W'(man_of(64'(data_1_i), MAN_W));
    assign b_m = MAN_W'(man_of(64'(data_2_i), MAN_W));
    always_ff @(posedge clk_i)
        if (rst_i) v1 <= 1'b0;
        else if (en) begin
            v1 <= valid_i;
            s1_sign <= a_s ^ b_s;
            s1_zero <= (a_e == '0) | (b_e == '0);
            s1_rne <= round_mode_i == RND_RNE;
            s1_es <= {1'b0, a_e} + {1'b0, b_e};
            s1_ma <= {1'b1, a_m};
            s1_mb <= {1'b1, b_m};
        end
    float_mant_mul #(.N(MAN_W + 1)) u_mul (
        .clk(clk_i),
        .en (en),
        .a  (s1_ma),
        .b  (s1_mb),
        .p  (s2_p)
    );
    // The exponent is kept biased-up (Es + n + c) so under/overflow are unsigned compares.
    always_comb begin
        n = s2_p[PW-1];
        m_raw = n ? s2_p[2*MAN_W:MAN_W+1] : s2_p[2*MAN_W-1:MAN_W];
        guard = n ? s2_p[MAN_W] : s2_p[MAN_W-1];
        sticky = n ? |s2_p[MAN_W-1:0] : |s2_p[MAN_W-2:0];
        inc = s2_rne & guard & (sticky | m_raw[0]);
        {c, m_rnd} = {1'b0, m_raw} + (MAN_W+1)'(inc);
        e_pre = XW'(s2_es) + XW'(n) + XW'(c);
        e_out = e_pre - XW'(BIAS);
        uf = ~s2_zero & (e_pre <= XW'(BIAS));
        of = ~s2_zero & ~uf & (e_out > XW'(2 ** EXP_W - 1));
        res = (s2_zero | uf) ? '0 : of ? {s2_sign, {(EXP_W + MAN_W){1'b1}}} : {s2_sign, e_out[EXP_W-1:0], m_rnd};
    end
    always_ff @(posedge clk_i)
        if (rst_i) begin
            v2 <= 1'b0;
            valid_o <= 1'b0;
            data_mult_o <= '0;
            overflow_o <= 1'b0;
            underflow_o <= 1'b0;
        end else if (en) begin
            v2 <= v1;
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_rne <= s1_rne;
            s2_es <= s1_es;
            valid_o <= v2;
            {overflow_o, underflow_o, data_mult_o} <= v2 ? {of, uf, res} : '0;
        end
endmodule

// File: tb/tb_float_mult_pipe.sv
// tb_float_mult_pipe: directed and random checks of float_mult_pipe against an
// integer-arithmetic reference model and a result scoreboard.
module tb_float_mult_pipe;
    logic clk = 1'b0, rst_i = 1'b1, valid_i = 1'b0, round_mode_i = 1'b0, ready_i = 1'b1;
    logic ready_o, valid_o, overflow_o, underflow_o, acc;
    logic [11:0] data_1_i = '0, data_2_i = '0, data_mult_o;
    logic [11:0] op_a[6], op_b[6];
    logic op_m[6];
    logic [13:0] exp_q[$];
    logic held = 1'b0;
    logic [13:0] held_val = '0;
    int tests = 0, fails = 0, idx;
    always #5 clk = ~clk;
    float_mult_pipe dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_1_i(data_1_i), .data_2_i(data_2_i), .round_mode_i(round_mode_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_mult_o(data_mult_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );
    // Returns {overflow, underflow, result}; value-level maths on integer significands.
    function automatic logic [13:0] model(input logic [11:0] a, input logic [11:0] b, input logic m);
        int ea, eb, e, sh, rem, half;
        longint p, q;
        logic s;
        ea = int'(a[10:6]);
        eb = int'(b[10:6]);
        s = a[11] ^ b[11];
        if (ea == 0 || eb == 0) return 14'h0;
        p = longint'({1'b1, a[5:0]}) * longint'({1'b1, b[5:0]});
        sh = (p >= 8192) ? 7 : 6;
        q = p >> sh;
        rem = int'(p - (q << sh));
        half = 1 << (sh - 1);
        if (m && (rem > half || (rem == half && q[0]))) q++;
        e = ea + eb - 15 + sh - 6;
        if (q == 128) begin q = 64; e++; end
        if (e <= 0) return 14'h1000;
        if (e > 31) return {2'b10, s, 11'h7ff};
        return {2'b00, s, e[4:0], q[5:0]};
    endfunction
    function automatic logic [11:0] rnd_op();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return {1'($urandom), 5'd0, 6'($urandom)};
        if (k == 1) return 12'($urandom);
        return {1'($urandom), 5'($urandom_range(10, 20)), 6'($urandom)};
    endfunction
    task automatic step(input logic v, input logic [11:0] a, input logic [11:0] b, input logic m, input logic r, output logic accepted);
        logic [13:0] got, want;
        valid_i = v; data_1_i = a; data_2_i = b; round_mode_i = m; ready_i = r;
        #1;
        got = {overflow_o, underflow_o, data_mult_o};
        accepted = v & ready_o & ~rst_i;
        if (held && !rst_i) begin
            tests++;
            assert (valid_o === 1'b1 && got === held_val) else begin fails++; $error("FAIL stall_hold: got v=%b %h required v=1 %h", valid_o, got, held_val); end
        end
        held = valid_o & ~r;
        held_val = got;
        if (!rst_i && valid_o && !r) begin
            tests++;
            assert (ready_o === 1'b0) else begin fails++; $error("FAIL ready_stall: got %b required 0", ready_o); end
        end
        if (!rst_i && r) begin
            tests++;
            assert (ready_o === 1'b1) else begin fails++; $error("FAIL ready_free: got %b required 1", ready_o); end
        end
        if (!rst_i && valid_o && r) begin
            tests++;
            assert (exp_q.size() != 0) else begin fails++; $error("FAIL spurious: got %h required no result", got); end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                tests++;
                assert (got === want) else begin fails++; $error("FAIL result: got %h required %h", got, want); end
            end
        end
        if (accepted) exp_q.push_back(model(a, b, m));
        if (rst_i) begin exp_q.delete(); held = 1'b0; end
        @(posedge clk);
        #1;
    endtask
    task automatic directed(input string tag, input logic [11:0] a, input logic [11:0] b, input logic m, input logic [13:0] want);
        logic ac;
        step(1'b1, a, b, m, 1'b1, ac);
        tests++;
        assert (ac === 1'b1) else begin fails++; $error("FAIL %s_accept: got %b required 1", tag, ac); end
        for (int i = 0; i < 2; i++) begin
            tests++;
            assert (valid_o === 1'b0) else begin fails++; $error("FAIL %s_early: got valid %b required 0", tag, valid_o); end
            step(1'b0, 12'h0, 12'h0, 1'b0, 1'b1, ac);
        end
        tests++;
        assert (valid_o === 1'b1 && {overflow_o, underflow_o, data_mult_o} === want) else begin
            fails++; $error("FAIL %s: got v=%b %h required v=1 %h", tag, valid_o, {overflow_o, underflow_o, data_mult_o}, want);
        end
        step(1'b0, 12'h0, 12'h0, 1'b0, 1'b1, ac);
    endtask
    initial begin
        step(1'b0, 12'h0, 12'h0, 1'b0, 1'b1, acc);
        step(1'b0, 12'h0, 12'h0, 1'b0, 1'b1, acc);
        rst_i = 1'b0;
        tests++;
        assert (valid_o === 1'b0) else begin fails++; $error("FAIL reset_valid: got %b required 0", valid_o); end
        tests++;
        assert ({overflow_o, underflow_o, data_mult_o} === 14'h0) else begin fails++; $error("FAIL reset_data: got %h required 0", {overflow_o, underflow_o, data_mult_o}); end
        directed("basic", 12'h3E0, 12'h3E0, 1'b0, 14'h0408);
        directed("sign", 12'hBC0, 12'h3E0, 1'b0, 14'h0BE0);
        directed("zero", 12'h000, 12'hBE0, 1'b0, 14'h0000);
        directed("rnd_trunc", 12'h3DF, 12'h3DF, 1'b0, 14'h0406);
        directed("rnd_rne", 12'h3DF, 12'h3DF, 1'b1, 14'h0407);
        directed("rnd_lo_trunc", 12'h3C1, 12'h3C1, 1'b0, 14'h03C2);
        directed("rnd_lo_rne", 12'h3C1, 12'h3C1, 1'b1, 14'h03C2);
        directed("overflow", 12'h7C0, 12'h400, 1'b0, 14'h27FF);
        directed("underflow", 12'h040, 12'h040, 1'b0, 14'h1000);
        for (int i = 0; i < 6; i++) begin op_a[i] = rnd_op(); op_b[i] = rnd_op(); op_m[i] = 1'($urandom); end
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            step(idx < 6, op_a[idx % 6], op_b[idx % 6], op_m[idx % 6], !(c >= 3 && c < 7), acc);
            if (acc) idx++;
        end
        tests++;
        assert (idx == 6 && exp_q.size() == 0) else begin fails++; $error("FAIL backpressure_drain: got %0d issued %0d pending required 6 and 0", idx, exp_q.size()); end
        for (int i = 0; i < 3; i++) step(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'b1, acc);
        rst_i = 1'b1;
        step(1'b1, 12'h3E0, 12'h3E0, 1'b0, 1'b0, acc);
        rst_i = 1'b0;
        tests++;
        assert (valid_o === 1'b0) else begin fails++; $error("FAIL midreset_valid: got %b required 0", valid_o); end
        tests++;
        assert (ready_o === 1'b1) else begin fails++; $error("FAIL midreset_ready: got %b required 1", ready_o); end
        for (int i = 0; i < 5; i++) step(1'b0, 12'h0, 12'h0, 1'b0, 1'b1, acc);
        directed("after_reset", 12'hBC0, 12'h3E0, 1'b0, 14'h0BE0);
        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 1'($urandom), $urandom_range(0, 3) != 0, acc);
        for (int c = 0; c < 10; c++) step(1'b0, 12'h0, 12'h0, 1'b0, 1'b1, acc);
        tests++;
        assert (exp_q.size() == 0) else begin fails++; $error("FAIL random_drain: got %0d pending required 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
